// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FRAME = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_LEN   = 2'b11;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_loader_if.sv
// Instruction-memory write port driven by the loader.
interface uart_loader_if #(
    parameter int ADDR_W = 14
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 serial byte receiver: rx synchronizer, oversample tick generator and bit FSM.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int OVS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [15:0] baud_div,
    output logic [7:0]  data,
    output logic        byte_valid,
    output logic        frame_err
);
    localparam int TW = $clog2(OVS) + 1;

    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] div_cnt;
    logic [15:0] div_m1;
    logic        tick;

    rx_state_t   state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        bv_d, fe_d;

    // Divide-by-0 and divide-by-1 both collapse to a tick on every cycle.
    assign div_m1 = (baud_div < 16'd2) ? 16'd0 : baud_div - 16'd1;
    assign tick   = (div_cnt >= div_m1);
    assign data   = shreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            div_cnt    <= 16'd0;
            state_q    <= RX_IDLE;
            tcnt_q     <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            div_cnt    <= tick ? 16'd0 : div_cnt + 16'd1;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_valid <= bv_d;
            frame_err  <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    state_d = RX_START;
                    tcnt_d  = '0;
                end
            end
            RX_START: begin
                // Mid-start recheck; a line back high means it was a glitch.
                if (tick) begin
                    if (tcnt_q == TW'(OVS/2 - 1)) begin
                        tcnt_d  = '0;
                        bit_d   = 3'd0;
                        state_d = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_q == TW'(OVS - 1)) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_s2, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RX_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_q == TW'(OVS - 1)) begin
                        state_d = RX_IDLE;
                        bv_d    = rx_s2;
                        fe_d    = !rx_s2;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_loader.sv
// Receives a framed program image over UART and writes it word by word into instruction memory.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int OVS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [15:0]          baud_div,
    input  logic                 start,
    uart_loader_if.master        imem,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           error
);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [7:0] rx_byte;
    logic       byte_valid, frame_err;

    ld_state_t         state_q, state_d;
    logic [15:0]       n_words_q, n_words_d;
    logic [16:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [16:0]       n_new;

    uart_rx_core #(.OVS(OVS)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .baud_div   (baud_div),
        .data       (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign busy            = state_q inside {ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
    assign done            = (state_q == ST_DONE);
    assign error           = err_q;
    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign n_new           = {1'b0, rx_byte, n_words_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_words_q  <= 16'd0;
            word_idx_q <= 17'd0;
            byte_idx_q <= 2'd0;
            word_buf_q <= 24'd0;
            csum_q     <= 8'd0;
            err_q      <= ERR_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            n_words_q  <= n_words_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            csum_q     <= csum_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_words_d  = n_words_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        csum_d     = csum_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (busy && frame_err) begin
            state_d = ST_ERR;
            err_d   = ERR_FRAME;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d    = ST_SYNC;
                        err_d      = ERR_NONE;
                        n_words_d  = 16'd0;
                        word_idx_d = 17'd0;
                        byte_idx_d = 2'd0;
                        csum_d     = 8'd0;
                    end
                end
                ST_SYNC: if (byte_valid && rx_byte == SYNC_BYTE) state_d = ST_LEN0;
                ST_LEN0: begin
                    if (byte_valid) begin
                        n_words_d[7:0] = rx_byte;
                        state_d        = ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (byte_valid) begin
                        n_words_d[15:8] = rx_byte;
                        if (n_new == 17'd0) begin
                            state_d = ST_CSUM;
                        end else if (n_new > MAX_WORDS) begin
                            state_d = ST_ERR;
                            err_d   = ERR_LEN;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Leave only after the last strobe has gone out, so imem_we stays within DATA.
                    if (word_idx_q == {1'b0, n_words_q}) begin
                        state_d = ST_CSUM;
                    end else if (byte_valid) begin
                        csum_d     = csum_q ^ rx_byte;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            we_d       = 1'b1;
                            addr_d     = word_idx_q[ADDR_W-1:0];
                            wdata_d    = {rx_byte, word_buf_q};
                            word_idx_d = word_idx_q + 17'd1;
                        end else begin
                            word_buf_d = {rx_byte, word_buf_q[23:8]};
                        end
                    end
                end
                ST_CSUM: begin
                    if (byte_valid) begin
                        if (rx_byte == csum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = ERR_CSUM;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: two instances (ADDR_W 14 and 4) driven by serial byte frames.
module tb_uart_loader;
    localparam int BIT = 32;  // baud_div 2 x OVS 16

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_a = 1'b1, rx_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] baud_div = 16'd2;
    logic        busy_a, done_a, busy_b, done_b;
    logic [1:0]  error_a, error_b;

    int n_cmp = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int wr_cnt_b = 0;
    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];

    uart_loader_if #(.ADDR_W(14)) mem_a ();
    uart_loader_if #(.ADDR_W(4))  mem_b ();

    uart_loader #(.ADDR_W(14), .OVS(16)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .baud_div(baud_div), .start(start_a),
        .imem(mem_a), .busy(busy_a), .done(done_a), .error(error_a)
    );
    uart_loader #(.ADDR_W(4), .OVS(16)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .baud_div(baud_div), .start(start_b),
        .imem(mem_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_a.imem_we) begin
            wr_addr.push_back(mem_a.imem_addr);
            wr_data.push_back(mem_a.imem_wdata);
        end
        if (mem_b.imem_we) wr_cnt_b++;
        if (dut_a.u_rx.byte_valid) bv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit = 1'b1);
        set_line(sel, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            repeat (BIT) @(negedge clk);
        end
        set_line(sel, stop_bit);
        repeat (BIT) @(negedge clk);
        set_line(sel, 1'b1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_seq(input int sel, input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(sel, bytes[i]);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start_a = 1'b1;
        else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int base;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_error", error_a, 2'b00);
        check("rst_we", mem_a.imem_we, 1'b0);
        check("rst_addr", mem_a.imem_addr, 14'd0);
        check("rst_wdata", mem_a.imem_wdata, 32'd0);

        // Two-word load; checksum 11^22^33^44^DE^AD^BE^EF = 66
        pulse_start(0);
        check("t1_busy", busy_a, 1'b1);
        send_seq(0, '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66});
        check("t1_nwr", wr_addr.size(), 2);
        check("t1_addr0", wr_addr[0], 14'd0);
        check("t1_data0", wr_data[0], 32'h11223344);
        check("t1_addr1", wr_addr[1], 14'd1);
        check("t1_data1", wr_data[1], 32'hDEADBEEF);
        check("t1_done", done_a, 1'b1);
        check("t1_error", error_a, 2'b00);
        check("t1_busy_end", busy_a, 1'b0);
        check("t1_hold_addr", mem_a.imem_addr, 14'd1);

        // Garbage before sync, plus a start pulse while busy that must be ignored
        base = wr_addr.size();
        pulse_start(0);
        check("t2_done_clr", done_a, 1'b0);
        send_seq(0, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02});
        pulse_start(0);
        send_seq(0, '{8'h03, 8'h04, 8'h04});
        check("t2_nwr", wr_addr.size(), base + 1);
        check("t2_addr", wr_addr[base], 14'd0);
        check("t2_data", wr_data[base], 32'h04030201);
        check("t2_done", done_a, 1'b1);
        check("t2_error", error_a, 2'b00);

        // Bad checksum: write still happens, then checksum error
        base = wr_addr.size();
        pulse_start(0);
        send_seq(0, '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        check("t3_nwr", wr_addr.size(), base + 1);
        check("t3_error", error_a, 2'b10);
        check("t3_busy", busy_a, 1'b0);
        check("t3_done", done_a, 1'b0);

        // Framing error inside a partial word
        base = wr_addr.size();
        pulse_start(0);
        check("t4_err_clr", error_a, 2'b00);
        send_seq(0, '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB});
        send_byte(0, 8'hCC, 1'b0);
        check("t4_error", error_a, 2'b01);
        check("t4_busy", busy_a, 1'b0);
        check("t4_nwr", wr_addr.size(), base);

        // One-tick low glitch while in SYNC, then an empty image (N=0, checksum 00)
        pulse_start(0);
        base = bv_cnt;
        rx_a = 1'b0;
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("t5_no_byte", bv_cnt, base);
        check("t5_busy", busy_a, 1'b1);
        check("t5_error", error_a, 2'b00);
        base = wr_addr.size();
        send_seq(0, '{8'hA5, 8'h00, 8'h00, 8'h00});
        check("t5_done", done_a, 1'b1);
        check("t5_nwr", wr_addr.size(), base);

        // ADDR_W=4: 17 words overflows, 16 words is accepted
        pulse_start(1);
        send_seq(1, '{8'hA5, 8'h11, 8'h00});
        check("t6_error", error_b, 2'b11);
        check("t6_busy", busy_b, 1'b0);
        check("t6_nwr", wr_cnt_b, 0);
        pulse_start(1);
        send_seq(1, '{8'hA5, 8'h10, 8'h00});
        check("t6_max_busy", busy_b, 1'b1);
        check("t6_max_error", error_b, 2'b00);

        // Reset after 5 of 8 data bytes
        base = wr_addr.size();
        pulse_start(0);
        send_seq(0, '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF});
        check("t7_pre_nwr", wr_addr.size(), base + 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_busy", busy_a, 1'b0);
        check("t7_done", done_a, 1'b0);
        check("t7_error", error_a, 2'b00);
        check("t7_addr", mem_a.imem_addr, 14'd0);
        check("t7_wdata", mem_a.imem_wdata, 32'd0);
        check("t7_busy_b", busy_b, 1'b0);
        send_seq(0, '{8'hBE, 8'hAD, 8'hDE, 8'h66});
        check("t7_post_nwr", wr_addr.size(), base + 1);
        check("t7_post_done", done_a, 1'b0);
        pulse_start(0);
        send_seq(0, '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        check("t7_new_nwr", wr_addr.size(), base + 2);
        check("t7_new_addr", wr_addr[base + 1], 14'd0);
        check("t7_new_data", wr_data[base + 1], 32'h04030201);
        check("t7_new_done", done_a, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
